// File: rtl/mips_memory_data_port.sv
// ----------------------------------------------------------------------------
// mips_memory_data_port
//
// MEM-stage data-memory access port. A request (store/load, access size,
// sign-extension flag, byte address, right-justified store data) is accepted
// in IDLE, and all of its fields are registered. Depending on the request:
//   - size None              -> immediate OK response, no memory traffic
//   - misaligned Half / Word -> immediate misaligned-fault response
//   - otherwise              -> one byte-strobed word request to memory.
//     A load then waits for read data, or times out.
// The port holds at most one transaction at a time.
//
// Parameters
//   BIG_ENDIAN : 1 = byte at address offset k lives in lane 3-k,
//                0 = byte at offset k lives in lane k
//   TIMEOUT    : number of WAIT cycles without read data before a
//                timeout fault (1..65535)
//
// Ports
//   clock, resetN                  clock, synchronous active-low reset
//   reqValid/reqReady              request handshake (ready only in IDLE)
//   writeEnable, byteEnable,
//   byteExtend, address, writeData request fields
//   memValid/memReady              memory request handshake
//   memAddr, memWrite, memStrobe,
//   memWriteData                   memory request payload (zero when idle)
//   memReadValid, memReadData      memory read-return channel
//   respValid/respReady            response handshake
//   respData, respFault            load result / fault code (0 OK,
//                                  1 misaligned, 2 timeout)
// ----------------------------------------------------------------------------
module mips_memory_data_port #(
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        writeEnable,
  input  logic [1:0]  byteEnable,
  input  logic        byteExtend,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        memValid,
  input  logic        memReady,
  output logic [29:0] memAddr,
  output logic        memWrite,
  output logic [3:0]  memStrobe,
  output logic [31:0] memWriteData,
  input  logic        memReadValid,
  input  logic [31:0] memReadData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respData,
  output logic [1:0]  respFault
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  localparam logic [1:0]  FAULT_OK       = 2'd0;
  localparam logic [1:0]  FAULT_MISALIGN = 2'd1;
  localparam logic [1:0]  FAULT_TIMEOUT  = 2'd2;
  // The counter holds the number of WAIT cycles already spent, so the
  // TIMEOUT-th WAIT cycle is the one that sees LAST_WAIT.
  localparam logic [15:0] LAST_WAIT      = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [1:0]  resp_fault_q, resp_fault_d;

  // Registered request fields
  logic        write_q;
  size_e       size_q;
  logic        extend_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  size_e       req_size;
  logic        accept;
  logic        misaligned;

  logic [1:0]  byte_lane;
  logic        upper_half;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [3:0]  strobe;
  logic [31:0] store_word;
  logic [31:0] load_word;

  assign req_size   = size_e'(byteEnable);
  assign accept     = reqValid && (state_q == ST_IDLE);
  assign misaligned = ((req_size == SZ_HALF) && address[0]) ||
                      ((req_size == SZ_WORD) && (address[1:0] != 2'b00));

  // Lane mapping: big-endian places the lowest-addressed byte in lane 3,
  // so the offset is simply inverted.
  assign byte_lane  = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
  assign upper_half = BIG_ENDIAN ? ~addr_q[1]   : addr_q[1];
  assign load_byte  = memReadData[{byte_lane, 3'b000} +: 8];
  assign load_half  = upper_half ? memReadData[31:16] : memReadData[15:0];

  // Strobes, lane-replicated store data and extended load data for the
  // registered request.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    strobe     = 4'b0000;
    store_word = wdata_q;
    load_word  = memReadData;
    case (size_q)
      SZ_BYTE: begin
        strobe     = 4'b0001 << byte_lane;
        store_word = {4{wdata_q[7:0]}};
        load_word  = {{24{extend_q & load_byte[7]}}, load_byte};
      end
      SZ_HALF: begin
        strobe     = upper_half ? 4'b1100 : 4'b0011;
        store_word = {2{wdata_q[15:0]}};
        load_word  = {{16{extend_q & load_half[15]}}, load_half};
      end
      SZ_WORD: begin
        strobe     = 4'b1111;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          count_d      = 16'd0;
          resp_data_d  = 32'd0;
          resp_fault_d = FAULT_OK;
          if (req_size == SZ_NONE) begin
            state_d = ST_RESP;
          end else if (misaligned) begin
            state_d      = ST_RESP;
            resp_fault_d = FAULT_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (memReady) begin
          state_d = write_q ? ST_RESP : ST_WAIT;
          count_d = 16'd0;
        end
      end
      ST_WAIT: begin
        // Read data takes priority over a timeout in the same cycle.
        if (memReadValid) begin
          state_d     = ST_RESP;
          resp_data_d = load_word;
        end else if (count_q == LAST_WAIT) begin
          state_d      = ST_RESP;
          resp_fault_d = FAULT_TIMEOUT;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (respReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs and they all update together.
    if (!resetN) begin
      state_q      <= ST_IDLE;
      count_q      <= 16'd0;
      resp_data_q  <= 32'd0;
      resp_fault_q <= FAULT_OK;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      write_q  <= 1'b0;
      size_q   <= SZ_NONE;
      extend_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      write_q  <= writeEnable;
      size_q   <= req_size;
      extend_q <= byteExtend;
      addr_q   <= address;
      wdata_q  <= writeData;
    end
  end

  // Outputs: the memory payload is only driven while a request is presented,
  // and the response payload only while it is valid.
  assign reqReady     = (state_q == ST_IDLE);
  assign memValid     = (state_q == ST_REQ);
  assign memAddr      = memValid ? addr_q[31:2] : 30'd0;
  assign memWrite     = memValid & write_q;
  assign memStrobe    = memValid ? strobe : 4'b0000;
  assign memWriteData = memValid ? store_word : 32'd0;
  assign respValid    = (state_q == ST_RESP);
  assign respData     = respValid ? resp_data_q : 32'd0;
  assign respFault    = respValid ? resp_fault_q : FAULT_OK;

endmodule

// File: tb/tb_mips_memory_data_port.sv
// ----------------------------------------------------------------------------
// tb_mips_memory_data_port
//
// Drives a little-endian and a big-endian instance (both TIMEOUT=4) with the
// same stimulus. The expected strobes, store data, load data, faults and
// latencies come from a byte-oriented reference model.
// ----------------------------------------------------------------------------
module tb_mips_memory_data_port;
  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        resetN;
  logic        reqValid, writeEnable, byteExtend;
  logic [1:0]  byteEnable;
  logic [31:0] address, writeData;
  logic        memReady, memReadValid, respReady;
  logic [31:0] memReadData;

  logic        req_ready  [2];
  logic        mem_valid  [2];
  logic [29:0] mem_addr   [2];
  logic        mem_write  [2];
  logic [3:0]  mem_strobe [2];
  logic [31:0] mem_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_data  [2];
  logic [1:0]  resp_fault [2];

  int total = 0;
  int bad   = 0;

  // Observations from the most recent transaction (index 0 = LE, 1 = BE)
  int          obs_lat    [2];
  int          obs_mv     [2];
  logic [3:0]  obs_strb   [2];
  logic [29:0] obs_maddr  [2];
  logic        obs_mwrite [2];
  logic [31:0] obs_mwd    [2];
  logic [31:0] obs_rdata  [2];
  logic [1:0]  obs_fault  [2];

  always #5 clock = ~clock;

  mips_memory_data_port #(.BIG_ENDIAN(1'b0), .TIMEOUT(TMO)) dut_le (
    .clock(clock), .resetN(resetN),
    .reqValid(reqValid), .reqReady(req_ready[0]),
    .writeEnable(writeEnable), .byteEnable(byteEnable), .byteExtend(byteExtend),
    .address(address), .writeData(writeData),
    .memValid(mem_valid[0]), .memReady(memReady), .memAddr(mem_addr[0]),
    .memWrite(mem_write[0]), .memStrobe(mem_strobe[0]), .memWriteData(mem_wdata[0]),
    .memReadValid(memReadValid), .memReadData(memReadData),
    .respValid(resp_valid[0]), .respReady(respReady),
    .respData(resp_data[0]), .respFault(resp_fault[0])
  );

  mips_memory_data_port #(.BIG_ENDIAN(1'b1), .TIMEOUT(TMO)) dut_be (
    .clock(clock), .resetN(resetN),
    .reqValid(reqValid), .reqReady(req_ready[1]),
    .writeEnable(writeEnable), .byteEnable(byteEnable), .byteExtend(byteExtend),
    .address(address), .writeData(writeData),
    .memValid(mem_valid[1]), .memReady(memReady), .memAddr(mem_addr[1]),
    .memWrite(mem_write[1]), .memStrobe(mem_strobe[1]), .memWriteData(mem_wdata[1]),
    .memReadValid(memReadValid), .memReadData(memReadData),
    .respValid(resp_valid[1]), .respReady(respReady),
    .respData(resp_data[1]), .respFault(resp_fault[1])
  );

  // One complete transaction: drive it, observe both instances, and compare
  // against the reference model. rv_dly < 0 means read data never returns.
  task automatic txn_and_verify(input string tag, input bit we, input bit [1:0] be,
                                input bit ext, input bit [31:0] addr, input bit [31:0] wd,
                                input bit [31:0] rd, input int rdy_dly, input int rv_dly,
                                input int resp_dly, input bit noise);
    bit [3:0]  e_strb  [2];
    bit [31:0] e_rdata [2];
    bit [31:0] e_mwd, v;
    bit [1:0]  e_fault;
    bit        e_mem, e_timeout, hs, hs_now, done, done_now, ready_bad;
    bit        held_bad [2];
    bit        moved_bad [2];
    int        e_lat, n, b, lane, cyc, rc, widx;

    // Reference model: the access covers bytes addr..addr+n-1; each byte
    // sits in its endian-defined lane; the lowest-addressed byte is the least
    // significant (LE) or the most significant (BE) byte of the value.
    n = (be == 2'd1) ? 1 : (be == 2'd2) ? 2 : (be == 2'd3) ? 4 : 0;
    e_mem     = (n > 0) && ((int'(addr[1:0]) % n) == 0);
    e_timeout = e_mem && !we && (rv_dly < 0 || rv_dly >= TMO);
    e_fault   = (n > 0 && !e_mem) ? 2'd1 : (e_timeout ? 2'd2 : 2'd0);
    if (!e_mem)         e_lat = 1;
    else if (we)        e_lat = 2 + rdy_dly;
    else if (e_timeout) e_lat = 2 + rdy_dly + TMO;
    else                e_lat = 3 + rdy_dly + rv_dly;
    e_mwd = (n == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
            (n == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    for (int d = 0; d < 2; d++) begin
      e_strb[d] = 4'b0000;
      v = 32'd0;
      for (int i = 0; i < (e_mem ? n : 0); i++) begin
        b    = int'(addr[1:0]) + i;
        lane = (d == 1) ? 3 - b : b;
        e_strb[d] = e_strb[d] | (4'b0001 << lane);
        v = v | (((rd >> (8 * lane)) & 32'hFF) << (8 * ((d == 1) ? n - 1 - i : i)));
      end
      if (ext && n > 0 && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
      e_rdata[d] = (e_mem && !we && !e_timeout) ? v : 32'd0;
    end

    total++;
    if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before got=%b%b exp=11", tag, req_ready[0], req_ready[1]);
    end
    reqValid = 1'b1; writeEnable = we; byteEnable = be; byteExtend = ext;
    address = addr; writeData = wd;
    memReady = 1'b0; memReadValid = 1'b0; respReady = 1'b0;
    @(posedge clock); #1;
    // Scramble the request inputs; with noise, keep offering a request
    // while busy, which must not be taken.
    reqValid = noise; writeEnable = 1'($urandom); byteEnable = 2'($urandom);
    byteExtend = 1'($urandom); address = $urandom; writeData = $urandom;

    cyc = 1; rc = 0; widx = 0; hs = 1'b0; done = 1'b0; ready_bad = 1'b0;
    for (int d = 0; d < 2; d++) begin
      obs_lat[d] = -1; obs_mv[d] = 0; held_bad[d] = 1'b0; moved_bad[d] = 1'b0;
      obs_strb[d] = '0; obs_maddr[d] = '0; obs_mwrite[d] = 1'b0; obs_mwd[d] = '0;
      obs_rdata[d] = '0; obs_fault[d] = '0;
    end
    while (!done && cyc < 300) begin
      memReady = 1'b0; respReady = 1'b0;
      memReadValid = noise ? 1'($urandom) : 1'b0;
      memReadData  = $urandom;
      if (req_ready[0] !== 1'b0 || req_ready[1] !== 1'b0) ready_bad = 1'b1;
      for (int d = 0; d < 2; d++) begin
        if (mem_valid[d] === 1'b1) begin
          if (obs_mv[d] == 0) begin
            obs_strb[d] = mem_strobe[d]; obs_maddr[d] = mem_addr[d];
            obs_mwrite[d] = mem_write[d]; obs_mwd[d] = mem_wdata[d];
          end else if ({mem_addr[d], mem_write[d], mem_strobe[d], mem_wdata[d]} !==
                       {obs_maddr[d], obs_mwrite[d], obs_strb[d], obs_mwd[d]}) begin
            moved_bad[d] = 1'b1;
          end
          obs_mv[d]++;
        end
        if (resp_valid[d] === 1'b1) begin
          if (obs_lat[d] < 0) begin
            obs_lat[d] = cyc; obs_rdata[d] = resp_data[d]; obs_fault[d] = resp_fault[d];
          end else if ({resp_data[d], resp_fault[d]} !== {obs_rdata[d], obs_fault[d]}) begin
            held_bad[d] = 1'b1;
          end
        end
      end
      if (mem_valid[0] === 1'b1 && obs_mv[0] == rdy_dly + 1) memReady = 1'b1;
      if (resp_valid[0] === 1'b1) begin
        if (rc == resp_dly) respReady = 1'b1;
        rc++;
      end else if (hs && !we) begin
        memReadValid = (widx == rv_dly);
        if (widx == rv_dly) memReadData = rd;
        widx++;
      end
      hs_now   = (mem_valid[0] === 1'b1) && memReady;
      done_now = (resp_valid[0] === 1'b1) && respReady;
      @(posedge clock); #1;
      cyc++;
      hs   = hs | hs_now;
      done = done_now;
    end
    reqValid = 1'b0; respReady = 1'b0; memReady = 1'b0; memReadValid = 1'b0;

    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s hang got=no_response exp=response within 300 cycles", tag);
    end
    total++;
    if (ready_bad) begin
      bad++;
      $display("FAIL %s ready_while_busy got=1 exp=0", tag);
    end
    total++;
    if ({req_ready[0], req_ready[1], resp_valid[0], resp_valid[1]} !== 4'b1100) begin
      bad++;
      $display("FAIL %s idle_after got=%b%b%b%b exp=1100", tag,
               req_ready[0], req_ready[1], resp_valid[0], resp_valid[1]);
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_lat[d] != e_lat) begin
        bad++;
        $display("FAIL %s latency dut%0d got=%0d exp=%0d", tag, d, obs_lat[d], e_lat);
      end
      total++;
      if (obs_fault[d] !== e_fault) begin
        bad++;
        $display("FAIL %s fault dut%0d got=%0d exp=%0d", tag, d, obs_fault[d], e_fault);
      end
      total++;
      if (obs_rdata[d] !== e_rdata[d]) begin
        bad++;
        $display("FAIL %s data dut%0d got=%h exp=%h", tag, d, obs_rdata[d], e_rdata[d]);
      end
      total++;
      if (held_bad[d]) begin
        bad++;
        $display("FAIL %s resp_hold dut%0d got=changed exp=held", tag, d);
      end
      total++;
      if (obs_mv[d] != (e_mem ? rdy_dly + 1 : 0)) begin
        bad++;
        $display("FAIL %s mem_valid_cycles dut%0d got=%0d exp=%0d", tag, d, obs_mv[d],
                 e_mem ? rdy_dly + 1 : 0);
      end
      if (e_mem) begin
        total++;
        if ({obs_strb[d], obs_maddr[d], obs_mwrite[d]} !== {e_strb[d], addr[31:2], we}) begin
          bad++;
          $display("FAIL %s mem_req dut%0d got=strb %b addr %h wr %b exp=strb %b addr %h wr %b",
                   tag, d, obs_strb[d], obs_maddr[d], obs_mwrite[d], e_strb[d], addr[31:2], we);
        end
        total++;
        if (moved_bad[d]) begin
          bad++;
          $display("FAIL %s mem_stable dut%0d got=changed exp=stable", tag, d);
        end
        if (we) begin
          total++;
          if (obs_mwd[d] !== e_mwd) begin
            bad++;
            $display("FAIL %s mem_wdata dut%0d got=%h exp=%h", tag, d, obs_mwd[d], e_mwd);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; reqValid = 1'b0; writeEnable = 1'b0; byteEnable = 2'd0;
    byteExtend = 1'b0; address = '0; writeData = '0;
    memReady = 1'b0; memReadValid = 1'b0; memReadData = '0; respReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({req_ready[d], mem_valid[d], mem_write[d], resp_valid[d], mem_addr[d],
           mem_strobe[d], mem_wdata[d], resp_data[d], resp_fault[d]} !==
          {1'b1, 3'b000, 30'd0, 4'd0, 32'd0, 32'd0, 2'd0}) begin
        bad++;
        $display("FAIL reset_state dut%0d got=rdy %b mv %b wr %b rv %b addr %h strb %b wd %h rd %h f %0d exp=rdy 1 rest 0",
                 d, req_ready[d], mem_valid[d], mem_write[d], resp_valid[d], mem_addr[d],
                 mem_strobe[d], mem_wdata[d], resp_data[d], resp_fault[d]);
      end
    end
    resetN = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_wait();
    reqValid = 1'b1; writeEnable = 1'b0; byteEnable = 2'd3; byteExtend = 1'b0;
    address = 32'h40;
    @(posedge clock); #1;
    reqValid = 1'b0; memReady = 1'b1;
    @(posedge clock); #1;
    memReady = 1'b0;
    resetN = 1'b0;
    @(posedge clock); #1;
    resetN = 1'b1; memReadValid = 1'b1; memReadData = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({req_ready[d], resp_valid[d], mem_valid[d]} !== 3'b100) begin
          bad++;
          $display("FAIL reset_mid_wait dut%0d cyc%0d got=rdy %b rv %b mv %b exp=rdy 1 rv 0 mv 0",
                   d, c, req_ready[d], resp_valid[d], mem_valid[d]);
        end
      end
      @(posedge clock); #1;
    end
    memReadValid = 1'b0;
  endtask

  task automatic test_signed_byte_load();
    txn_and_verify("sbyte_load", 1'b0, 2'd1, 1'b1, 32'h1003, $urandom, 32'h80AABBCC, 0, 0, 0, 1'b0);
    total++;
    if ({obs_strb[0], obs_maddr[0], obs_rdata[0], obs_fault[0]} !==
        {4'b1000, 30'h400, 32'hFFFFFF80, 2'd0} || obs_lat[0] != 3) begin
      bad++;
      $display("FAIL sbyte_load_le got=strb %b addr %h data %h f %0d lat %0d exp=strb 1000 addr 400 data ffffff80 f 0 lat 3",
               obs_strb[0], obs_maddr[0], obs_rdata[0], obs_fault[0], obs_lat[0]);
    end
  endtask

  task automatic test_half_store();
    txn_and_verify("half_store", 1'b1, 2'd2, 1'b0, 32'h2002, 32'h1234ABCD, $urandom, 3, 0, 0, 1'b0);
    total++;
    if ({obs_strb[0], obs_mwd[0], obs_mwrite[0]} !== {4'b1100, 32'hABCDABCD, 1'b1} ||
        obs_mv[0] != 4 || obs_lat[0] != 5) begin
      bad++;
      $display("FAIL half_store_le got=strb %b wd %h wr %b mv %0d lat %0d exp=strb 1100 wd abcdabcd wr 1 mv 4 lat 5",
               obs_strb[0], obs_mwd[0], obs_mwrite[0], obs_mv[0], obs_lat[0]);
    end
  endtask

  task automatic test_misaligned();
    txn_and_verify("misaligned_word", 1'b0, 2'd3, 1'b0, 32'h0006, $urandom, $urandom, 0, 0, 4, 1'b0);
    total++;
    if ({obs_fault[0], obs_rdata[0]} !== {2'd1, 32'd0} || obs_mv[0] != 0 || obs_lat[0] != 1) begin
      bad++;
      $display("FAIL misaligned_le got=f %0d data %h mv %0d lat %0d exp=f 1 data 0 mv 0 lat 1",
               obs_fault[0], obs_rdata[0], obs_mv[0], obs_lat[0]);
    end
    txn_and_verify("misaligned_half", 1'b1, 2'd2, 1'b0, 32'h0103, $urandom, $urandom, 0, 0, 1, 1'b0);
  endtask

  task automatic test_timeout();
    txn_and_verify("timeout", 1'b0, 2'd3, 1'b0, 32'h0010, $urandom, $urandom, 0, -1, 0, 1'b0);
    total++;
    if (obs_fault[0] !== 2'd2 || obs_lat[0] != 2 + TMO) begin
      bad++;
      $display("FAIL timeout_le got=f %0d lat %0d exp=f 2 lat %0d", obs_fault[0], obs_lat[0], 2 + TMO);
    end
    // Read data in the last WAIT cycle beats the timeout.
    txn_and_verify("timeout_edge", 1'b0, 2'd3, 1'b0, 32'h0020, $urandom, 32'h13579BDF, 1, TMO - 1, 0, 1'b0);
    total++;
    if (obs_fault[0] !== 2'd0 || obs_rdata[0] !== 32'h13579BDF) begin
      bad++;
      $display("FAIL timeout_edge_le got=f %0d data %h exp=f 0 data 13579bdf", obs_fault[0], obs_rdata[0]);
    end
  endtask

  task automatic test_be_half_load_and_none();
    txn_and_verify("be_half_load", 1'b0, 2'd2, 1'b0, 32'h0, $urandom, 32'hF00D1234, 0, 0, 0, 1'b0);
    total++;
    if ({obs_strb[1], obs_rdata[1]} !== {4'b1100, 32'h0000F00D}) begin
      bad++;
      $display("FAIL be_half_load_be got=strb %b data %h exp=strb 1100 data 0000f00d",
               obs_strb[1], obs_rdata[1]);
    end
    txn_and_verify("size_none", 1'b0, 2'd0, 1'b1, 32'h0, $urandom, 32'hFFFFFFFF, 0, 0, 0, 1'b0);
    total++;
    if (obs_rdata[1] !== 32'd0 || obs_mv[1] != 0 || obs_lat[1] != 1) begin
      bad++;
      $display("FAIL size_none_be got=data %h mv %0d lat %0d exp=data 0 mv 0 lat 1",
               obs_rdata[1], obs_mv[1], obs_lat[1]);
    end
  endtask

  task automatic test_back_to_back_random();
    bit [31:0] addr;
    bit [1:0]  be;
    for (int k = 0; k < 80; k++) begin
      be   = 2'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (be == 2'd3)      addr[1:0] = 2'b00;
        else if (be == 2'd2) addr[0]   = 1'b0;
      end
      txn_and_verify($sformatf("rand%0d", k), 1'($urandom), be, 1'($urandom), addr,
                     $urandom, $urandom, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 6)) - 1, int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_signed_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_be_half_load_and_none();
    test_reset_mid_wait();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=still running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_memory_data_port.md
Name: mips_memory_data_port

Overview:
Data-memory access port for the MEM stage. It consumes the memory control triple (writeEnable, byteEnable, byteExtend) together with the effective address and store data. It drives a word-wide, byte-strobed memory with a valid/ready request channel and a separate read-return channel. It returns aligned, extended load data, or a fault code, on a valid/ready response channel.

Parameters:
BIG_ENDIAN, 0, 1 = byte lane 3-addr[1:0]; 0 = byte lane addr[1:0]
TIMEOUT, 255, max cycles in WAIT for memReadValid before a timeout fault (1..65535)

Ports:
clock  input  1  rising-edge clock
resetN  input  1  synchronous reset, active-low
reqValid  input  1  request present
reqReady  output  1  port accepts request
writeEnable  input  1  1 = store, 0 = load
byteEnable  input  2  0 None, 1 Byte, 2 Half, 3 Word
byteExtend  input  1  1 Signed, 0 Unsigned (loads only)
address  input  32  byte address
writeData  input  32  store data, right-justified
memValid  output  1  memory request valid
memReady  input  1  memory accepts request
memAddr  output  30  word address (address[31:2])
memWrite  output  1  write request
memStrobe  output  4  byte-lane strobes
memWriteData  output  32  lane-replicated store data
memReadValid  input  1  read data return valid
memReadData  input  32  read data word
respValid  output  1  response valid
respReady  input  1  response consumer ready
respData  output  32  load result (0 for stores/faults)
respFault  output  2  0 OK, 1 misaligned, 2 timeout

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset (resetN=0 at a rising edge): state goes to IDLE. All outputs go to 0 except reqReady=1. The timeout counter is cleared. Any in-flight memory transaction is abandoned, and a later memReadValid is ignored.
- reqReady=1 only in IDLE. A request is accepted on reqValid&reqReady, and all request fields are registered.
- Accept with byteEnable=None: go to RESP with respData=0, respFault=0. No memory traffic.
- Misaligned accept: Half with address[0]=1, or Word with address[1:0]!=0. Go to RESP with respFault=1, respData=0. No memory traffic.
- Otherwise go to REQ.
- REQ: memValid=1. memAddr, memWrite and memStrobe are held stable until memReady.
  - Byte strobe: one-hot at lane L, where L is set by the BIG_ENDIAN rule.
  - Half strobe: 0011 for lane 0, 1100 for lane 2. Lanes are reversed when BIG_ENDIAN=1.
  - Word strobe: 1111.
  - memWriteData: a Byte store replicates writeData[7:0] into all 4 lanes. A Half store replicates writeData[15:0] into both halves. A Word store passes writeData through.
  - On memReadValid... not applicable here; on memReady, a store goes to RESP (respFault=0, respData=0) and a load goes to WAIT.
- WAIT: memValid=0. The counter increments each cycle.
  - memReadValid=1: extract the addressed lane(s) of memReadData. Zero-extend or sign-extend to 32 bits per byteExtend; Word ignores byteExtend. Latch into respData and go to RESP.
  - Counter reaches TIMEOUT without memReadValid: go to RESP with respFault=2, respData=0.
  - memReadValid and timeout in the same cycle: the data wins.
- RESP: respValid=1. respData and respFault are held until respReady, then the FSM returns to IDLE. memReadValid is ignored outside WAIT.
- Latency from accept at edge T:
  - Fault or None: respValid in cycle T+1.
  - Store with immediate memReady: respValid in T+2.
  - Load with immediate memReady and memReadValid in the first WAIT cycle: respValid in T+3.
- No back-to-back overlap: at most one outstanding transaction.

Test Plan:
1. Reset mid-operation: assert resetN=0 in WAIT, then drive memReadValid=1 after release -> reqReady=1, respValid stays 0, no response emitted.
2. Signed byte load: byteEnable=1, byteExtend=1, address=0x1003, BIG_ENDIAN=0, memReadData=0x80AABBCC -> memStrobe=1000, memAddr=0x400, respData=0xFFFFFF80, respFault=0, respValid at T+3.
3. Half store: byteEnable=2, writeEnable=1, address=0x2002, writeData=0x1234ABCD -> memStrobe=1100, memWriteData=0xABCDABCD, memWrite=1; with memReady delayed 3 cycles, memValid and signals stay stable and respValid follows 1 cycle after memReady.
4. Misaligned word: byteEnable=3, address=0x0006 -> no memValid, respFault=1, respData=0 at T+1; hold respReady=0 for 4 cycles -> response held, reqReady=0.
5. Timeout: TIMEOUT=4, load accepted and memReady given, memReadValid never asserted -> respFault=2 after 4 WAIT cycles.
6. Unsigned half load, big-endian: BIG_ENDIAN=1, byteEnable=2, byteExtend=0, address=0x0, memReadData=0xF00D1234 -> memStrobe=1100, respData=0x0000F00D. Also byteEnable=0 -> respData=0, no memValid.
